// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: FSM state type, round constants, IVs and round functions.
package sha256_pkg;

   typedef enum logic [1:0] {
      eIdle = 2'd0,
      eBusy = 2'd1,
      eAdd  = 2'd2,
      eDone = 2'd3
   } state_e;

   localparam logic [31:0] K [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [255:0] IV_256 = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   localparam logic [255:0] IV_224 = {
      32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
   };

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
      return (e & f) ^ (~e & g);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
      return (a & b) ^ (a & c) ^ (b & c);
   endfunction

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
   endfunction

endpackage

// File: rtl/sha256_round.sv
// One combinational SHA-256 compression round; working variables packed a..h from MSB down.
module sha256_round
   import sha256_pkg::*;
(
   input  logic [255:0] work,
   input  logic [31:0]  k,
   input  logic [31:0]  w,
   output logic [255:0] work_next
);

   logic [31:0] a, b, c, d, e, f, g, h;
   logic [31:0] t1, t2;

   assign {a, b, c, d, e, f, g, h} = work;
   assign t1 = h + bsig1(e) + ch(e, f, g) + k + w;
   assign t2 = bsig0(a) + maj(a, b, c);
   assign work_next = {t1 + t2, a, b, c, d + t1, e, f, g};

endmodule

// File: rtl/sha256_stream_core.sv
// Multi-block SHA-256 engine with chained hash state; SHA-224 mode when SHA256_STREAM_CORE_SHA224_EN is defined.
// state | meaning:  eIdle | ready for a block,  eBusy | rounds running,  eAdd | feed-forward,  eDone | digest held
module sha256_stream_core
   import sha256_pkg::*;
#(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk_i,
   input  logic         reset_n_i,
   input  logic         v_i,
   output logic         ready_o,
   input  logic [511:0] block_i,
   input  logic         first_i,
   input  logic         last_i,
`ifdef SHA256_STREAM_CORE_SHA224_EN
   input  logic         sha224_i,
`endif
   output logic         v_o,
   input  logic         yumi_i,
   output logic [255:0] digest_o
);

   localparam int R = ROUNDS_PER_CYCLE;

   if (!(R == 1 || R == 2 || R == 4 || R == 8)) begin : g_bad_rpc
      $error("sha256_stream_core: ROUNDS_PER_CYCLE must be 1, 2, 4 or 8");
   end

   localparam logic [5:0] T_LAST = 6'(64 - R);

   state_e       state;
   logic [31:0]  win      [16];
   logic [31:0]  win_next [16];
   logic [31:0]  ext      [16+R];
   logic [255:0] work, h_reg, h_sum, iv_sel, round_out;
   logic [5:0]   t;
   logic         last_q, msg_active, mode_224, load_iv;

`ifdef SHA256_STREAM_CORE_SHA224_EN
   assign iv_sel = sha224_i ? IV_224 : IV_256;
`else
   assign iv_sel   = IV_256;
   assign mode_224 = 1'b0;
`endif

   assign ready_o = (state == eIdle);
   assign v_o     = (state == eDone);
   assign load_iv = first_i | ~msg_active;

   // Extend the window by R words so R rounds can consume W[t..t+R-1] and slide forward.
   always_comb begin
      for (int i = 0; i < 16; i++) ext[i] = win[i];
      for (int j = 0; j < R; j++)
         ext[16+j] = ssig1(ext[14+j]) + ext[9+j] + ssig0(ext[1+j]) + ext[j];
      for (int i = 0; i < 16; i++) win_next[i] = ext[R+i];
   end

   for (genvar r = 0; r < R; r++) begin : g_rnd
      logic [255:0] cur, nxt;
      if (r == 0) begin : g_head
         assign cur = work;
      end else begin : g_link
         assign cur = g_rnd[r-1].nxt;
      end
      sha256_round u_round (
         .work      (cur),
         .k         (K[t + 6'(r)]),
         .w         (win[r]),
         .work_next (nxt)
      );
   end

   assign round_out = g_rnd[R-1].nxt;

   always_comb begin
      h_sum = '0;
      for (int i = 0; i < 8; i++) h_sum[32*i +: 32] = h_reg[32*i +: 32] + work[32*i +: 32];
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         state      <= eIdle;
         t          <= '0;
         h_reg      <= '0;
         work       <= '0;
         digest_o   <= '0;
         msg_active <= 1'b0;
         last_q     <= 1'b0;
`ifdef SHA256_STREAM_CORE_SHA224_EN
         mode_224   <= 1'b0;
`endif
         for (int i = 0; i < 16; i++) win[i] <= '0;
      end else begin
         case (state)
            eIdle: if (v_i) begin
               for (int i = 0; i < 16; i++) win[i] <= block_i[511 - 32*i -: 32];
               last_q <= last_i;
               t      <= '0;
               if (load_iv) begin
                  h_reg <= iv_sel;
                  work  <= iv_sel;
`ifdef SHA256_STREAM_CORE_SHA224_EN
                  mode_224 <= sha224_i;
`endif
               end else begin
                  work <= h_reg;
               end
               state <= eBusy;
            end
            eBusy: begin
               work <= round_out;
               win  <= win_next;
               t    <= t + 6'(R);
               if (t == T_LAST) state <= eAdd;
            end
            eAdd: begin
               h_reg <= h_sum;
               if (last_q) begin
                  digest_o   <= mode_224 ? {h_sum[255:32], 32'h0} : h_sum;
                  msg_active <= 1'b0;
                  state      <= eDone;
               end else begin
                  msg_active <= 1'b1;
                  state      <= eIdle;
               end
            end
            eDone: if (yumi_i) state <= eIdle;
            default: state <= eIdle;
         endcase
      end
   end

endmodule
